mat_diag_streamer: RTL and testbench
====================================

MAT_DIAG_STREAMER -- requirements
Module: mat_diag_streamer

Interface
REQ-001 SHALL have parameter WIDTH, default 128, meaning matrix edge and lane count.
REQ-002 SHALL have parameter DIAG_SIZE, default 1+$clog2(WIDTH), meaning diagonal index width.
REQ-003 SHALL have parameter CACHE_SIZE, default 4, meaning matrix-cache slots; CACHE_ADDR_SIZE, default $clog2(CACHE_SIZE), meaning slot address width.
REQ-004 SHALL have ports: clock in 1, the single clock; reset in 1, synchronous active-high reset.
REQ-005 SHALL have ports: cmd_valid in 1, a tile command is offered; cmd_ready out 1, the command is accepted this cycle; cmd_addr in CACHE_ADDR_SIZE, tile slot; cmd_last in 1, final tile of the stream.
REQ-006 SHALL have ports: read_enable out 1, cache read strobe; read_addr1 out CACHE_ADDR_SIZE, current tile; read_addr2 out CACHE_ADDR_SIZE, previous tile; read_diag out DIAG_SIZE, diagonal index; cache_data in WIDTH x shortreal, combinational cache read data.
REQ-007 SHALL have ports: out_valid out 1; out_ready in 1; out_data out WIDTH x shortreal; out_mask out WIDTH, per-lane data-valid; out_last out 1, final diagonal of the stream; busy out 1, not IDLE.

Function
REQ-008 SHALL implement states IDLE, STREAM, GAP and DRAIN, with diagonal counter d and flag has_prev.
REQ-009 IDLE SHALL assert cmd_ready, and on handshake SHALL set cur=cmd_addr, has_prev=0, d=0, and go to STREAM.
REQ-010 A diagonal SHALL issue (read_enable=1) only when the output register is empty or being consumed (out_valid&out_ready); d SHALL advance only on issue.
REQ-011 On issue, read_addr1=cur, read_addr2=prev, read_diag=d; cache_data SHALL be captured into out_data with out_valid=1 in the next cycle (latency 1).
REQ-012 In STREAM, out_mask[i]=1 iff i<=d, or has_prev=1 and i>d.
REQ-013 Issuing d=WIDTH-1 in STREAM: if the tile is last, SHALL go to DRAIN with d=0; else, if cmd_valid, SHALL accept the command in the same cycle (cmd_ready=1) and set prev=cur, cur=cmd_addr, has_prev=1, d=0; else SHALL go to GAP.
REQ-014 GAP SHALL assert cmd_ready, issue nothing, and on handshake behave as the non-last hand-off in REQ-013.
REQ-015 DRAIN SHALL issue d=0..WIDTH-2 with read_addr2=cur and out_mask[i]=1 iff i>d; after issuing WIDTH-2 it SHALL return to IDLE.
REQ-016 out_last SHALL accompany the final issued diagonal: DRAIN d=WIDTH-2, or for WIDTH==1 the STREAM diagonal of the last tile.
REQ-017 While out_valid=1 and out_ready=0, out_data, out_mask and out_last SHALL hold stable.
REQ-018 cmd_ready SHALL be 0 in DRAIN and in STREAM except at the REQ-013 hand-off.

Reset
REQ-019 Reset SHALL force IDLE, d=0, has_prev=0, out_valid=0, out_last=0, out_mask=0, read_enable=0 and busy=0, and SHALL discard any in-flight diagonal, including mid-STREAM or mid-DRAIN.

Configuration
REQ-020 With MAT_STREAM_PERF_EN defined, SHALL add output perf_stall_cycles [31:0], reset 0, incrementing each cycle out_valid=1 and out_ready=0, and saturating at all-ones.
REQ-021 Without MAT_STREAM_PERF_EN, the port and counter SHALL be absent.

Structure
REQ-022 The shared mat package SHALL hold the state enum and the default WIDTH/CACHE_SIZE constants.
REQ-023 The one-entry output register with valid/ready SHALL be a sub-module named mat_stream_reg.

Verification
REQ-024 WIDTH=4, one cmd (addr 2, last=1), out_ready=1: 7 beats; read_diag sequence 0,1,2,3,0,1,2; masks 0001,0011,0111,1111,1110,1100,1000; out_last on beat 7 only.
REQ-025 Two back-to-back cmds (1, then 3 last) with cmd_valid held: no bubble between tiles; tile-2 diagonals have read_addr1=3, read_addr2=1, mask 1111.
REQ-026 cmd_valid dropped after tile 1 for 5 cycles: GAP holds with busy=1 and no read_enable; streaming resumes on the next command with has_prev=1.
REQ-027 out_ready low for 3 cycles mid-tile: out_data stable, no read_enable, d frozen; with MAT_STREAM_PERF_EN, perf_stall_cycles=3.
REQ-028 reset asserted on DRAIN d=1: next cycle IDLE, out_valid=0, cmd_ready=1.

Source files
------------

// File: rtl/mat_pkg.sv
// mat_pkg: shared streamer state encoding, default geometry and lane data type.
package mat_pkg;
  localparam int MAT_WIDTH = 128;
  localparam int MAT_CACHE_SIZE = 4;
  typedef enum logic [1:0] {IDLE, STREAM, GAP, DRAIN} mat_state_e;
  // Lanes carry IEEE-754 single-precision values as raw 32-bit patterns.
  typedef logic [31:0] fp32_t;
endpackage

// File: rtl/mat_stream_reg.sv
// mat_stream_reg: one-entry valid/ready output register holding a diagonal beat.
module mat_stream_reg import mat_pkg::*; #(
  parameter int WIDTH = MAT_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load,
  input  fp32_t [WIDTH-1:0]      in_data,
  input  logic  [WIDTH-1:0]      in_mask,
  input  logic                   in_last,
  input  logic                   out_ready,
  output logic                   ready,
  output logic                   out_valid,
  output fp32_t [WIDTH-1:0]      out_data,
  output logic  [WIDTH-1:0]      out_mask,
  output logic                   out_last
);
  assign ready = !out_valid || out_ready;
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mask  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_mask  <= in_mask;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/mat_diag_streamer.sv
// mat_diag_streamer: streams matrix-tile diagonals from a cache, stitching consecutive tiles.
// Optional MAT_STREAM_PERF_EN adds a saturating output-stall cycle counter.
module mat_diag_streamer import mat_pkg::*; #(
  parameter int WIDTH = MAT_WIDTH,
  parameter int DIAG_SIZE = 1 + $clog2(WIDTH),
  parameter int CACHE_SIZE = MAT_CACHE_SIZE,
  parameter int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [CACHE_ADDR_SIZE-1:0] cmd_addr,
  input  logic                       cmd_last,
  output logic                       read_enable,
  output logic [CACHE_ADDR_SIZE-1:0] read_addr1,
  output logic [CACHE_ADDR_SIZE-1:0] read_addr2,
  output logic [DIAG_SIZE-1:0]       read_diag,
  input  fp32_t [WIDTH-1:0]          cache_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output fp32_t [WIDTH-1:0]          out_data,
  output logic  [WIDTH-1:0]          out_mask,
  output logic                       out_last,
`ifdef MAT_STREAM_PERF_EN
  output logic [31:0]                perf_stall_cycles,
`endif
  output logic                       busy
);
  localparam logic [DIAG_SIZE-1:0] D_TOP = DIAG_SIZE'(WIDTH - 1);
  localparam logic [DIAG_SIZE-1:0] D_END = DIAG_SIZE'(WIDTH - 2);
  mat_state_e state, state_n;
  logic [DIAG_SIZE-1:0] d, d_n;
  logic [CACHE_ADDR_SIZE-1:0] cur, cur_n, prev, prev_n;
  logic has_prev, has_prev_n, last_tile, last_tile_n;
  logic can, top_d, last_n;
  logic [WIDTH-1:0] mask_n;
  assign busy = state != IDLE;
  assign read_addr1 = cur;
  assign read_addr2 = state == DRAIN ? cur : prev;
  assign read_diag = d;
  always_comb begin
    read_enable = can && (state == STREAM || state == DRAIN);
    top_d = d == D_TOP;
    cmd_ready = state == IDLE || state == GAP || (state == STREAM && read_enable && top_d && !last_tile);
    state_n = state;
    d_n = d;
    cur_n = cur;
    prev_n = prev;
    has_prev_n = has_prev;
    last_tile_n = last_tile;
    if (cmd_valid && cmd_ready) begin
      state_n = STREAM;
      d_n = '0;
      cur_n = cmd_addr;
      last_tile_n = cmd_last;
      prev_n = state == IDLE ? prev : cur;
      has_prev_n = state != IDLE;
    end else if (read_enable) begin
      d_n = (state == STREAM ? top_d : d == D_END) ? '0 : d + 1'b1;
      if (state == STREAM && top_d) state_n = last_tile ? (WIDTH == 1 ? IDLE : DRAIN) : GAP;
      if (state == DRAIN && d == D_END) state_n = IDLE;
    end
    for (int i = 0; i < WIDTH; i++) mask_n[i] = state == DRAIN ? i > int'(d) : i <= int'(d) || has_prev;
    last_n = state == DRAIN ? d == D_END : WIDTH == 1 && last_tile;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      d <= '0;
      cur <= '0;
      prev <= '0;
      has_prev <= 1'b0;
      last_tile <= 1'b0;
    end else begin
      state <= state_n;
      d <= d_n;
      cur <= cur_n;
      prev <= prev_n;
      has_prev <= has_prev_n;
      last_tile <= last_tile_n;
    end
  end
  mat_stream_reg #(.WIDTH(WIDTH)) u_reg (
    .clock(clock),
    .reset(reset),
    .load(read_enable),
    .in_data(cache_data),
    .in_mask(mask_n),
    .in_last(last_n),
    .out_ready(out_ready),
    .ready(can),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_mask(out_mask),
    .out_last(out_last)
  );
`ifdef MAT_STREAM_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) perf_stall_cycles <= '0;
    else if (out_valid && !out_ready && !(&perf_stall_cycles)) perf_stall_cycles <= perf_stall_cycles + 1'b1;
  end
`endif
endmodule

// File: tb/tb_mat_diag_streamer.sv
// tb_mat_diag_streamer: scoreboard bench for the diagonal streamer at WIDTH=4.
module tb_mat_diag_streamer;
  import mat_pkg::*;
  typedef struct {
    logic [1:0] a1;
    logic [1:0] a2;
    logic       chk2;
    logic [2:0] dg;
    logic [3:0] mask;
    logic       last;
  } beat_t;
  logic clock = 0, reset = 1;
  logic cmd_valid = 0, cmd_last = 0, out_ready = 1;
  logic [1:0] cmd_addr = 0;
  logic cmd_ready, read_enable, out_valid, out_last, busy;
  logic [1:0] read_addr1, read_addr2;
  logic [2:0] read_diag;
  fp32_t [3:0] cache_data, out_data;
  logic [3:0] out_mask;
`ifdef MAT_STREAM_PERF_EN
  logic [31:0] perf_stall_cycles;
`endif
  beat_t exp_iss[$], exp_out[$];
  int vectors = 0, miscompares = 0;
  int busy_cnt = 0, issue_cnt = 0, out_cnt = 0;
  logic sb_en = 1;
  always #5 clock = ~clock;
  mat_diag_streamer #(.WIDTH(4), .CACHE_SIZE(4)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_last(cmd_last),
    .read_enable(read_enable), .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_diag(read_diag), .cache_data(cache_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mask(out_mask), .out_last(out_last),
`ifdef MAT_STREAM_PERF_EN
    .perf_stall_cycles(perf_stall_cycles),
`endif
    .busy(busy)
  );
  always_comb
    for (int i = 0; i < 4; i++) cache_data[i] = {8'(read_addr1), 8'(read_diag), 8'(i), 8'hA5};
  task automatic push_tile(input logic [1:0] a, input logic hp, input logic [1:0] p);
    beat_t b;
    for (int d = 0; d < 4; d++) begin
      b.a1 = a; b.a2 = p; b.chk2 = hp; b.dg = 3'(d); b.last = 1'b0;
      for (int i = 0; i < 4; i++) b.mask[i] = (i <= d) || hp;
      exp_iss.push_back(b);
      exp_out.push_back(b);
    end
  endtask
  task automatic push_drain(input logic [1:0] a);
    beat_t b;
    for (int d = 0; d < 3; d++) begin
      b.a1 = a; b.a2 = a; b.chk2 = 1'b1; b.dg = 3'(d); b.last = d == 2;
      for (int i = 0; i < 4; i++) b.mask[i] = i > d;
      exp_iss.push_back(b);
      exp_out.push_back(b);
    end
  endtask
  always @(negedge clock) begin
    beat_t b;
    fp32_t [3:0] ed;
    if (sb_en && !reset) begin
      if (busy) busy_cnt++;
      if (read_enable) begin
        issue_cnt++;
        vectors++;
        if (exp_iss.size() == 0) begin
          miscompares++;
          $display("FAIL issue_unexpected: diag=%0d addr1=%0d, none required", read_diag, read_addr1);
        end else begin
          b = exp_iss.pop_front();
          if (read_addr1 !== b.a1 || read_diag !== b.dg || (b.chk2 && read_addr2 !== b.a2)) begin
            miscompares++;
            $display("FAIL issue: got a1=%0d a2=%0d d=%0d, need a1=%0d a2=%0d d=%0d",
                     read_addr1, read_addr2, read_diag, b.a1, b.a2, b.dg);
          end
        end
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        vectors++;
        if (exp_out.size() == 0) begin
          miscompares++;
          $display("FAIL beat_unexpected: mask=%b, none required", out_mask);
        end else begin
          b = exp_out.pop_front();
          for (int i = 0; i < 4; i++) ed[i] = {8'(b.a1), 8'(b.dg), 8'(i), 8'hA5};
          if (out_data !== ed || out_mask !== b.mask || out_last !== b.last) begin
            miscompares++;
            $display("FAIL beat: got data=%h mask=%b last=%b, need data=%h mask=%b last=%b",
                     out_data, out_mask, out_last, ed, b.mask, b.last);
          end
        end
      end
    end
  end
  task automatic test_reset;
    reset = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    vectors++;
    if (out_valid !== 0 || busy !== 0 || read_enable !== 0 || cmd_ready !== 1 || out_mask !== 0 || out_last !== 0) begin
      miscompares++;
      $display("FAIL reset: got v=%b busy=%b re=%b rdy=%b mask=%b last=%b, need 0 0 0 1 0000 0",
               out_valid, busy, read_enable, cmd_ready, out_mask, out_last);
    end
    @(posedge clock); #1 reset = 0;
  endtask
  task automatic test_single;
    @(posedge clock); #1;
    busy_cnt = 0; issue_cnt = 0; out_cnt = 0;
    push_tile(2, 0, 0); push_drain(2);
    cmd_valid = 1; cmd_addr = 2; cmd_last = 1;
    @(posedge clock); #1 cmd_valid = 0;
    for (int c = 0; c < 50 && (exp_out.size() != 0 || busy); c++) @(negedge clock);
    @(negedge clock);
    vectors++;
    if (exp_out.size() != 0 || out_cnt != 7 || issue_cnt != 7 || busy_cnt != 7) begin
      miscompares++;
      $display("FAIL single: got left=%0d beats=%0d issues=%0d busy=%0d, need 0 7 7 7",
               exp_out.size(), out_cnt, issue_cnt, busy_cnt);
    end
  endtask
  task automatic test_back_to_back;
    bit seen = 0;
    @(posedge clock); #1;
    busy_cnt = 0; issue_cnt = 0;
    push_tile(1, 0, 0); push_tile(3, 1, 1); push_drain(3);
    cmd_valid = 1; cmd_addr = 1; cmd_last = 0;
    @(posedge clock); #1 cmd_addr = 3; cmd_last = 1;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      seen = cmd_ready;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL handoff_timeout: got cmd_ready=0, need 1");
    end
    @(posedge clock); #1 cmd_valid = 0;
    for (int c = 0; c < 50 && (exp_out.size() != 0 || busy); c++) @(negedge clock);
    @(negedge clock);
    vectors++;
    if (exp_out.size() != 0 || issue_cnt != 11 || busy_cnt != 11) begin
      miscompares++;
      $display("FAIL back_to_back: got left=%0d issues=%0d busy=%0d, need 0 11 11",
               exp_out.size(), issue_cnt, busy_cnt);
    end
  endtask
  task automatic test_gap;
    @(posedge clock); #1;
    push_tile(0, 0, 0);
    cmd_valid = 1; cmd_addr = 0; cmd_last = 0;
    @(posedge clock); #1 cmd_valid = 0;
    for (int c = 0; c < 20 && exp_iss.size() != 0; c++) @(negedge clock);
    @(negedge clock);
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (busy !== 1 || read_enable !== 0 || cmd_ready !== 1) begin
        miscompares++;
        $display("FAIL gap_hold[%0d]: got busy=%b re=%b rdy=%b, need 1 0 1", k, busy, read_enable, cmd_ready);
      end
      @(negedge clock);
    end
    push_tile(1, 1, 0); push_drain(1);
    @(posedge clock); #1 cmd_valid = 1; cmd_addr = 1; cmd_last = 1;
    @(posedge clock); #1 cmd_valid = 0;
    for (int c = 0; c < 50 && (exp_out.size() != 0 || busy); c++) @(negedge clock);
    @(negedge clock);
    vectors++;
    if (exp_out.size() != 0 || busy !== 0) begin
      miscompares++;
      $display("FAIL gap_resume: got left=%0d busy=%b, need 0 0", exp_out.size(), busy);
    end
  endtask
  task automatic test_stall;
    fp32_t [3:0] ed;
    for (int i = 0; i < 4; i++) ed[i] = {8'd2, 8'd1, 8'(i), 8'hA5};
    @(posedge clock); #1;
    push_tile(2, 0, 0); push_drain(2);
    cmd_valid = 1; cmd_addr = 2; cmd_last = 1;
    @(posedge clock); #1 cmd_valid = 0;
    repeat (2) @(posedge clock);
    #1 out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      vectors++;
      if (read_enable !== 0 || read_diag !== 3'd2 || out_valid !== 1 || out_data !== ed || out_mask !== 4'b0011) begin
        miscompares++;
        $display("FAIL stall[%0d]: got re=%b d=%0d v=%b data=%h mask=%b, need 0 2 1 %h 0011",
                 k, read_enable, read_diag, out_valid, out_data, out_mask, ed);
      end
    end
    @(posedge clock); #1 out_ready = 1;
    for (int c = 0; c < 50 && (exp_out.size() != 0 || busy); c++) @(negedge clock);
    @(negedge clock);
    vectors++;
    if (exp_out.size() != 0) begin
      miscompares++;
      $display("FAIL stall_done: got left=%0d, need 0", exp_out.size());
    end
`ifdef MAT_STREAM_PERF_EN
    vectors++;
    if (perf_stall_cycles !== 32'd3) begin
      miscompares++;
      $display("FAIL perf_stall: got %0d, need 3", perf_stall_cycles);
    end
`endif
  endtask
  task automatic test_reset_drain;
    @(posedge clock); #1;
    sb_en = 0;
    cmd_valid = 1; cmd_addr = 1; cmd_last = 1;
    @(posedge clock); #1 cmd_valid = 0;
    repeat (6) @(negedge clock);
    vectors++;
    if (read_enable !== 1 || read_diag !== 3'd1 || read_addr2 !== 2'd1 || busy !== 1) begin
      miscompares++;
      $display("FAIL drain_d1: got re=%b d=%0d a2=%0d busy=%b, need 1 1 1 1", read_enable, read_diag, read_addr2, busy);
    end
    reset = 1;
    @(negedge clock);
    vectors++;
    if (out_valid !== 0 || cmd_ready !== 1 || busy !== 0 || read_enable !== 0 || out_mask !== 0 || out_last !== 0) begin
      miscompares++;
      $display("FAIL reset_drain: got v=%b rdy=%b busy=%b re=%b mask=%b last=%b, need 0 1 0 0 0000 0",
               out_valid, cmd_ready, busy, read_enable, out_mask, out_last);
    end
    @(posedge clock); #1 reset = 0; sb_en = 1;
  endtask
  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_gap;
    test_stall;
    test_reset_drain;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
